// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants for the Goldschmidt divider datapath
package div_pkg;

    // Datapath word width between divider iteration stages.
    localparam int DATA_W = 16;

    // Number of register stages between N/D refine iterations.
    localparam int STAGES = 3;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data register slot of the elastic pipeline
module pipe_stage #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid bit follows the upstream slot on every load; flush drops it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
        end
    end

    // Data only moves with a real word, so bubbles leave the register untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= RESET_VAL;
        end else if (!i_flush && i_load && i_valid) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - DEPTH-stage valid/ready pipeline register with occupancy
module pipe_reg_elastic
    import div_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter int               DEPTH     = STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH:0]   w_rdy;
    logic             w_tail_full;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    r_occ;

    // A stage may load when downstream accepts or some stage at/after it is a
    // bubble; computed as a running AND from the output end so no signal feeds itself.
    always_comb begin
        w_rdy        = '0;
        w_tail_full  = 1'b1;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_tail_full = w_tail_full & w_valid[i];
            w_rdy[i]    = out_ready | ~w_tail_full;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (g == 0) begin : g_first
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_next
            assign w_src_valid = w_valid[g-1];
            assign w_src_data  = w_data[g-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk   (clk),
            .i_reset (reset),
            .i_flush (flush),
            .i_load  (w_rdy[g]),
            .i_valid (w_src_valid),
            .i_data  (w_src_data),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    assign in_ready   = w_rdy[0] & ~flush & ~reset;
    assign out_valid  = w_valid[DEPTH-1];
    assign out_data   = w_data[DEPTH-1];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy tracks accepted minus retired words; flush/reset empty the pipe.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - scoreboard bench for pipe_reg_elastic
module tb_pipe_reg_elastic;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;

    logic             in_ready2;
    logic [WIDTH-1:0] out_data2;
    logic             out_valid2;
    logic [1:0]       occupancy2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(16'hA5A5)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .occupancy (occupancy2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: reference FIFO of accepted words, checked at negedge.
    always @(negedge clk) begin
        logic exp_rdy;
        if (reset) begin
            chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
            exp_q.delete();
        end else begin
            exp_rdy = !flush && ((exp_q.size() < DEPTH) || out_ready);
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            chk("occupancy", {30'b0, occupancy}, 32'(exp_q.size()));
            chk("popcount_valid", 32'($countones(dut.w_valid)), 32'(exp_q.size()));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {16'b0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", {16'b0, out_data}, {16'b0, exp_q.pop_front()});
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && exp_rdy) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;

        // Reset with input offered
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_occ", {30'b0, occupancy}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'h0000);
        chk("rst_in_ready_d", {31'b0, in_ready}, 32'd0);
        chk("rst_val_a5a5", {16'b0, out_data2}, 32'hA5A5);

        // Streaming
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_data = 16'h3333; tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("str_out_valid", {31'b0, out_valid}, 32'd1);
        chk("str_data0", {16'b0, out_data}, 32'h1111);
        chk("str_occ_peak", {30'b0, occupancy}, 32'd3);
        tick();
        @(negedge clk);
        chk("str_data1", {16'b0, out_data}, 32'h2222);
        tick();
        @(negedge clk);
        chk("str_data2", {16'b0, out_data}, 32'h3333);
        tick();
        @(negedge clk);
        chk("str_empty", {31'b0, out_valid}, 32'd0);

        // Backpressure
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'(i);
            tick();
        end
        in_data = 16'h0004;
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_occ", {30'b0, occupancy}, 32'd3);
        chk("bp_head", {16'b0, out_data}, 32'h0001);
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("bp_order", {16'b0, out_data}, 32'(i));
            tick();
        end
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Bubble collapse
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 16'hBBBB; tick();
        in_valid = 1'b0; tick();
        @(negedge clk);
        chk("bub_valid_map", {29'b0, dut.w_valid}, 32'b110);
        chk("bub_occ", {30'b0, occupancy}, 32'd2);
        chk("bub_head", {16'b0, out_data}, 32'hAAAA);
        chk("bub_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush with input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'h0C00 + 16'(i);
            tick();
        end
        in_data = 16'hDEAD;
        flush   = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_occ", {30'b0, occupancy}, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 16'h5555; tick();
        in_data = 16'h6666; tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_occ", {30'b0, occupancy}, 32'd0);
        chk("mrst_out_data", {16'b0, out_data}, 32'h0000);
        tick();

        // Random traffic against the reference FIFO
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            flush     = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        @(negedge clk);
        chk("final_model_empty", 32'(exp_q.size()), 32'd0);
        chk("final_out_valid", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
